// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte sources.
// The serializer runs from the system clock; one bit lasts CLOCK_FREQ/BAUD cycles.
module uart_tx_arbiter #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD       = 115200,
    parameter int NUM_REQ    = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int DIV   = CLOCK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
    localparam logic [2:0]       PTR_RESET = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic [2:0]       grant_reg, grant_next;
    logic [2:0]       last_ptr, last_next;

    logic [7:0]  valid_ext;
    logic [63:0] data_ext;
    logic        found;
    logic [2:0]  pick;
    logic [7:0]  pick_byte;
    logic        handshake;
    logic        bit_tick;

    // Zero-extend to the 8-requester maximum so a 3-bit index always fits.
    assign valid_ext = 8'(req_valid);
    assign data_ext  = 64'(req_data);

    // Search upward from the requester after the last winner, wrapping.
    always_comb begin
        logic [2:0] cand;
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the tool infers a latch to hold its old value.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 3'((int'(last_ptr) + 1 + k) % NUM_REQ);
            if (!found && valid_ext[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_byte = data_ext[{pick, 3'b000} +: 8];
    assign handshake = (state == S_IDLE) && found;
    assign bit_tick  = (baud_cnt == LAST_TICK);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = handshake && (pick == 3'(i));
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        grant_next = grant_reg;
        last_next  = last_ptr;

        unique case (state)
            S_IDLE: begin
                tx_next   = 1'b1;
                baud_next = '0;
                bit_next  = '0;
                if (handshake) begin
                    shift_next = pick_byte;
                    grant_next = pick;
                    last_next  = pick;
                    tx_next    = 1'b0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    baud_next  = '0;
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_next   = '0;
                        tx_next    = 1'b1;
                        state_next = S_STOP;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        tx_next    = shift_reg[0];
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    baud_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Reset also clears the latched byte so an abandoned frame leaves nothing behind.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from
        // pre-edge values, matching flop behaviour regardless of statement order.
        if (RST) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            grant_reg <= '0;
            last_ptr  <= PTR_RESET;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            grant_reg <= grant_next;
            last_ptr  <= last_next;
        end
    end

    assign uart_tx  = tx_reg;
    assign busy     = (state != S_IDLE);
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a line monitor decodes each frame and
// compares it with the byte/grant expected when the stimulus was queued.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;

    typedef struct {
        logic [7:0] data;
        logic [2:0] gid;
        logic       b2b;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 RST = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx;
    logic                 busy;
    logic [2:0]           grant_id;

    uart_tx_arbiter #(
        .CLOCK_FREQ(1000000),
        .BAUD      (100000),
        .NUM_REQ   (NUM_REQ)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       exp_q[$];

    logic [NUM_REQ-1:0] hs_prev = '0;
    int ready_cnt0 = 0;
    int ready_cnt1 = 0;
    int viol = 0;

    // Handshake is decided by valid&ready just before the next rising edge.
    always @(negedge clk) begin
        if (RST) begin
            hs_prev = '0;
        end else begin
            hs_prev = req_valid & req_ready;
            if (busy && req_ready != '0) viol++;
            if ($countones(req_ready) > 1) viol++;
        end
    end

    // Requester model: hold each byte until its handshake, then move on.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs_prev[0]) begin
                void'(q0.pop_front());
                ready_cnt0++;
            end
            if (hs_prev[1]) begin
                void'(q1.pop_front());
                ready_cnt1++;
            end
            req_valid[0]  = (q0.size() != 0);
            req_valid[1]  = (q1.size() != 0);
            req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
            req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
        end
    end

    // Line monitor: DIV=10, sample each bit in its middle cycle.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    int         busy_cnt = 0;
    int         neg_cyc = 0;
    int         end_cyc = -1000;
    int         mon_gap = 0;
    int         frames_done = 0;
    logic [7:0] mon_byte = '0;
    exp_t       cur;

    always @(negedge clk) begin
        neg_cyc++;
        if (RST) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                busy_cnt   = (busy === 1'b1) ? 1 : 0;
                mon_gap    = neg_cyc - end_cyc;
            end
        end else begin
            mon_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (mon_cnt == 5) begin
                check("start_bit", 32'(uart_tx), 32'(0));
            end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                mon_byte[3'((mon_cnt - 15) / 10)] = uart_tx;
            end else if (mon_cnt == 95) begin
                check("stop_bit", 32'(uart_tx), 32'(1));
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(exp_q.size()), 32'(1));
                end else begin
                    cur = exp_q.pop_front();
                    check("frame_data", 32'(mon_byte), 32'(cur.data));
                    check("grant_id", 32'(grant_id), 32'(cur.gid));
                    if (cur.b2b) check("idle_gap", 32'(mon_gap), 32'(1));
                end
            end else if (mon_cnt == 100) begin
                check("busy_len", 32'(busy_cnt), 32'(100));
                check("idle_line", 32'(uart_tx), 32'(1));
                mon_active  = 1'b0;
                end_cyc     = neg_cyc;
                frames_done++;
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic [2:0] g, input logic b);
        exp_t e;
        e.data = d;
        e.gid  = g;
        e.b2b  = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = frames_done + n;
        budget = n * 110 + 50;
        while (frames_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    initial begin
        int budget;

        // 1: reset, nothing valid
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("rst_tx", 32'(uart_tx), 32'(1));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_ready", 32'(req_ready), 32'(0));
        end
        @(posedge clk);
        #1 RST = 1'b0;

        // 2: single byte from requester 0, ready in the same cycle as valid
        @(negedge clk);
        q0.push_back(8'hA5);
        push_exp(8'hA5, 3'd0, 1'b0);
        @(posedge clk);
        #2;
        check("single_ready", 32'(req_ready), 32'(2'b01));
        check("pre_frame_tx", 32'(uart_tx), 32'(1));
        @(posedge clk);
        #2;
        check("tx_low_after_hs", 32'(uart_tx), 32'(0));
        wait_frames(1);
        check("single_ready_cnt", 32'(ready_cnt0), 32'(1));

        // 3: contention from reset
        @(posedge clk);
        #1 RST = 1'b1;
        @(negedge clk);
        q0.push_back(8'h11);
        q1.push_back(8'h22);
        push_exp(8'h11, 3'd0, 1'b0);
        push_exp(8'h22, 3'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        wait_frames(2);
        @(negedge clk);
        q0.push_back(8'h33);
        q1.push_back(8'h44);
        push_exp(8'h33, 3'd0, 1'b0);
        push_exp(8'h44, 3'd1, 1'b1);
        wait_frames(2);

        // 4: fairness with both requesters saturated
        @(negedge clk);
        ready_cnt0 = 0;
        ready_cnt1 = 0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'(8'h50 + i));
            q1.push_back(8'(8'h90 + i));
        end
        for (int i = 0; i < 3; i++) begin
            push_exp(8'(8'h50 + i), 3'd0, (i != 0));
            push_exp(8'(8'h90 + i), 3'd1, 1'b1);
        end
        wait_frames(6);
        check("ready_pulses0", 32'(ready_cnt0), 32'(3));
        check("ready_pulses1", 32'(ready_cnt1), 32'(3));

        // 5: reset mid-frame, pointer returns so requester 0 wins again
        @(negedge clk);
        q0.push_back(8'h00);
        budget = 200;
        do begin
            @(posedge clk);
            budget--;
        end while (!(mon_active && mon_cnt >= 34) && budget > 0);
        check("mid_frame_reached", 32'(mon_active), 32'(1));
        #1 RST = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(uart_tx), 32'(1));
        check("abort_busy", 32'(busy), 32'(0));
        RST = 1'b0;
        @(negedge clk);
        q0.push_back(8'h5A);
        q1.push_back(8'h6B);
        push_exp(8'h5A, 3'd0, 1'b0);
        push_exp(8'h6B, 3'd1, 1'b1);
        wait_frames(2);

        // 6: late request waits for the next idle cycle
        @(negedge clk);
        q0.push_back(8'hC3);
        push_exp(8'hC3, 3'd0, 1'b0);
        budget = 200;
        do begin
            @(posedge clk);
            budget--;
        end while (!(mon_active && mon_cnt >= 20) && budget > 0);
        @(negedge clk);
        q1.push_back(8'h3C);
        push_exp(8'h3C, 3'd1, 1'b1);
        @(posedge clk);
        #2;
        check("late_ready_blocked", 32'(req_ready), 32'(0));
        wait_frames(2);

        check("ready_rules", 32'(viol), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
